// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO result registers.
// A multiply or divide takes N+2 edges: one launch, N iterations, then sign correction.
module muldiv_unit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         hi_we,
  input  logic         lo_we,
  input  logic [N-1:0] wd,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [2*N-1:0] acc_q;
  logic [N-1:0]   opnd_q;
  logic [N-1:0]   hi_q;
  logic [N-1:0]   lo_q;
  logic           isDiv_q;
  logic           negQ_q;
  logic           negR_q;
  logic           dz_q;
  logic           busy_q;
  logic           done_q;
  logic           dbz_q;

  logic           signedOp;
  logic [N-1:0]   aMag;
  logic [N-1:0]   bMag;
  logic           negQ_d;
  logic           negR_d;
  logic [N:0]     mulSum;
  logic [2*N-1:0] mulNext;
  logic [N:0]     divShift;
  logic [N-1:0]   divDiff;
  logic           divGe;
  logic [2*N-1:0] divNext;
  logic [2*N-1:0] prodFix;
  logic [N-1:0]   quot;
  logic [N-1:0]   rem;
  logic [N-1:0]   fixHi;
  logic [N-1:0]   fixLo;

  // Signed ops iterate on magnitudes; the result signs are remembered separately.
  always_comb begin
    signedOp = op[0];
    aMag     = (signedOp && A[N-1]) ? -A : A;
    bMag     = (signedOp && B[N-1]) ? -B : B;
    negQ_d   = signedOp & (A[N-1] ^ B[N-1]);
    negR_d   = signedOp & A[N-1];
  end

  // acc_q holds {partial product, multiplier} or {partial remainder, dividend/quotient}.
  always_comb begin
    mulSum   = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, opnd_q} : {(N+1){1'b0}});
    mulNext  = {mulSum, acc_q[N-1:1]};
    divShift = acc_q[2*N-1:N-1];
    divGe    = (divShift >= {1'b0, opnd_q});
    divDiff  = divShift[N-1:0] - opnd_q;
    divNext  = {(divGe ? divDiff : divShift[N-1:0]), acc_q[N-2:0], divGe};
  end

  always_comb begin
    prodFix = negQ_q ? -acc_q : acc_q;
    quot    = acc_q[N-1:0];
    rem     = acc_q[2*N-1:N];
    fixHi   = prodFix[2*N-1:N];
    fixLo   = prodFix[N-1:0];
    if (isDiv_q) begin
      fixLo = dz_q ? {N{1'b1}} : (negQ_q ? -quot : quot);
      fixHi = negR_q ? -rem : rem;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      isDiv_q <= 1'b0;
      negQ_q  <= 1'b0;
      negR_q  <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            isDiv_q <= op[1];
            negQ_q  <= negQ_d;
            negR_q  <= negR_d;
            dz_q    <= op[1] && (B == '0);
            opnd_q  <= op[1] ? bMag : aMag;
            acc_q   <= {{N{1'b0}}, (op[1] ? aMag : bMag)};
            cnt_q   <= CW'(N - 1);
            busy_q  <= 1'b1;
            dbz_q   <= 1'b0;
            state_q <= RUN;
          end else begin
            // Move-to writes only land when no operation is being launched.
            if (hi_we) hi_q <= wd;
            if (lo_we) lo_q <= wd;
          end
        end
        RUN: begin
          acc_q <= isDiv_q ? divNext : mulNext;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) state_q <= FIX;
        end
        FIX: begin
          hi_q    <= fixHi;
          lo_q    <= fixLo;
          done_q  <= 1'b1;
          dbz_q   <= dz_q;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: an arithmetic reference model checked every cycle,
// plus hand-computed literal expectations for each directed operation.
module tb_muldiv_unit;

  localparam int N = 32;

  logic          clk;
  logic          reset;
  logic          start;
  logic [1:0]    op;
  logic [N-1:0]  A;
  logic [N-1:0]  B;
  logic          hi_we;
  logic          lo_we;
  logic [N-1:0]  wd;
  logic          busy;
  logic          done;
  logic          div_by_zero;
  logic [N-1:0]  hi;
  logic [N-1:0]  lo;

  int nChecks = 0;
  int nPass   = 0;

  muldiv_unit #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .hi_we(hi_we), .lo_we(lo_we), .wd(wd),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference result {div_by_zero, hi, lo} from plain 64-bit arithmetic.
  function automatic logic [64:0] modelOp(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa;
    longint sb;
    logic [63:0] p;
    logic [63:0] q;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: begin
        p = {32'b0, a} * {32'b0, b};
        return {1'b0, p};
      end
      2'b01: begin
        p = 64'(sa * sb);
        return {1'b0, p};
      end
      2'b10: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFFFFFF};
        return {1'b0, a % b, a / b};
      end
      default: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFFFFFF};
        q = 64'(sa / sb);
        r = 64'(sa % sb);
        return {1'b0, r[31:0], q[31:0]};
      end
    endcase
  endfunction

  int          remaining;
  logic        mBusy;
  logic        mDone;
  logic        mDbz;
  logic [31:0] mHi;
  logic [31:0] mLo;
  logic [64:0] pend;

  // Cycle model: a launched op stays busy for N+1 cycles, then results appear with done.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      remaining <= 0;
      mBusy     <= 1'b0;
      mDone     <= 1'b0;
      mDbz      <= 1'b0;
      mHi       <= '0;
      mLo       <= '0;
      pend      <= '0;
    end else begin
      mDone <= 1'b0;
      if (remaining > 0) begin
        remaining <= remaining - 1;
        if (remaining == 1) begin
          mBusy <= 1'b0;
          mDone <= 1'b1;
          mDbz  <= pend[64];
          mHi   <= pend[63:32];
          mLo   <= pend[31:0];
        end
      end else if (start) begin
        pend      <= modelOp(op, A, B);
        remaining <= N + 1;
        mBusy     <= 1'b1;
        mDbz      <= 1'b0;
      end else begin
        if (hi_we) mHi <= wd;
        if (lo_we) mLo <= wd;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Every-cycle comparison against the model, sampled away from the rising edge.
  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("model_busy", 32'(busy), 32'(mBusy));
      checkOutput("model_done", 32'(done), 32'(mDone));
      checkOutput("model_dbz", 32'(div_by_zero), 32'(mDbz));
      checkOutput("model_hi", hi, mHi);
      checkOutput("model_lo", lo, mLo);
    end
  end

  // Caller is at a falling edge; start is held for exactly one rising edge.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(output int busyCnt, output int cyc);
    busyCnt = 0;
    cyc     = 0;
    while (!done && cyc < 100) begin
      if (busy) busyCnt++;
      @(negedge clk);
      cyc++;
    end
    if (!done) checkOutput("done_timeout", 32'(cyc), 32'd0);
  endtask

  task automatic runOp(input string name, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expHi,
                       input logic [31:0] expLo, input logic expDbz);
    int bc;
    int cy;
    applyStimulus(o, a, b);
    waitDone(bc, cy);
    checkOutput({name, "_hi"}, hi, expHi);
    checkOutput({name, "_lo"}, lo, expLo);
    checkOutput({name, "_dbz"}, 32'(div_by_zero), 32'(expDbz));
  endtask

  initial begin
    int bc;
    int cy;
    reset = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    A     = '0;
    B     = '0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    wd    = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_dbz", 32'(div_by_zero), 32'd0);
    checkOutput("reset_hi", hi, 32'd0);
    checkOutput("reset_lo", lo, 32'd0);

    // Largest unsigned product, with exact busy/done timing.
    applyStimulus(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    waitDone(bc, cy);
    checkOutput("multu_busy_cycles", 32'(bc), 32'd33);
    checkOutput("multu_done_pos", 32'(cy), 32'd33);
    checkOutput("multu_hi", hi, 32'hFFFFFFFE);
    checkOutput("multu_lo", lo, 32'h00000001);

    // Launched in the done cycle: must be accepted.
    applyStimulus(2'b01, 32'hFFFFFFFD, 32'd7);
    checkOutput("b2b_busy", 32'(busy), 32'd1);
    waitDone(bc, cy);
    checkOutput("mult_hi", hi, 32'hFFFFFFFF);
    checkOutput("mult_lo", lo, 32'hFFFFFFEB);

    runOp("divu", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    runOp("div_neg", 2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    runOp("div_negb", 2'b11, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0);
    runOp("divu_zero", 2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1);
    @(negedge clk);
    checkOutput("dbz_held", 32'(div_by_zero), 32'd1);
    runOp("div_zero", 2'b11, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1);
    runOp("div_ovf", 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0);

    // Second start and an mthi while busy must both be ignored.
    @(negedge clk);
    applyStimulus(2'b01, 32'd3, 32'd4);
    repeat (3) @(negedge clk);
    start = 1'b1;
    op    = 2'b01;
    A     = 32'd9;
    B     = 32'd9;
    @(negedge clk);
    start = 1'b0;
    hi_we = 1'b1;
    wd    = 32'h1234;
    @(negedge clk);
    hi_we = 1'b0;
    checkOutput("busy_mthi_ignored", hi, 32'd0);
    waitDone(bc, cy);
    checkOutput("ignore_lo", lo, 32'd12);
    checkOutput("ignore_hi", hi, 32'd0);

    // Idle move-to writes.
    @(negedge clk);
    hi_we = 1'b1;
    wd    = 32'h1234;
    @(negedge clk);
    hi_we = 1'b0;
    checkOutput("mthi_hi", hi, 32'h1234);
    checkOutput("mthi_no_done", 32'(done), 32'd0);
    hi_we = 1'b1;
    lo_we = 1'b1;
    wd    = 32'h5678;
    @(negedge clk);
    hi_we = 1'b0;
    lo_we = 1'b0;
    checkOutput("mtboth_hi", hi, 32'h5678);
    checkOutput("mtboth_lo", lo, 32'h5678);

    // start and hi_we together: start wins.
    hi_we = 1'b1;
    wd    = 32'hAAAA;
    applyStimulus(2'b00, 32'd5, 32'd5);
    hi_we = 1'b0;
    checkOutput("start_wins_hi", hi, 32'h5678);
    waitDone(bc, cy);
    checkOutput("mul25_lo", lo, 32'd25);
    checkOutput("mul25_hi", hi, 32'd0);

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    applyStimulus(2'b10, 32'd1000, 32'd3);
    repeat (8) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_busy", 32'(busy), 32'd0);
    checkOutput("async_done", 32'(done), 32'd0);
    checkOutput("async_hi", hi, 32'd0);
    checkOutput("async_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) begin
      @(negedge clk);
      checkOutput("post_reset_no_done", 32'(done), 32'd0);
    end
    runOp("multu_after_reset", 2'b00, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);

    @(negedge clk);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit alongside the ALU's Logical/arith slices in the execute stage.
- Consumes the same A/B register operands the ALU receives.
- Produces HI/LO results for mult/multu/div/divu, and holds them for mfhi/mflo.
- The writeback mux consumes hi/lo. The controller stalls on busy.

Parameters:
- N, 32, operand width; hi and lo are each N bits; iteration count is N.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  launch operation with op/A/B; sampled on rising clk.
- op  input  2  00 multu, 01 mult, 10 divu, 11 div.
- A  input  N  multiplicand / dividend.
- B  input  N  multiplier / divisor.
- hi_we  input  1  mthi write strobe.
- lo_we  input  1  mtlo write strobe.
- wd  input  N  data for mthi/mtlo.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse: hi/lo newly valid.
- div_by_zero  output  1  valid with done; 1 if a divide had B==0.
- hi  output  N  HI register (product upper half / remainder).
- lo  output  N  LO register (product lower half / quotient).

Behaviour:
- One clock; reset is asynchronous and active-high: clk, reset.
- Reset (any time, including mid-operation):
  - state=IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0; iteration counter=0.
  - Operation in flight is discarded.
- States: IDLE, RUN, FIX.
- IDLE:
  - start=1 latches op, |A| and |B| (magnitudes for signed ops, raw for unsigned), plus the result sign bits.
  - Counter loads N-1; next state RUN.
- RUN:
  - One radix-2 step per cycle.
  - Multiply: shift-add into a 2N-bit accumulator.
  - Divide: restoring shift-subtract; quotient bit = 1 when partial remainder >= divisor.
  - Counter decrements; at 0, next state FIX.
- FIX:
  - Apply sign correction and write hi/lo.
  - Next state IDLE.
  - done=1 and div_by_zero are registered for the first IDLE cycle.
- Timing:
  - start sampled at edge k; busy=1 for cycles k+1..k+N+1 (N+1 cycles).
  - hi/lo update and done=1 in cycle k+N+2 only.
  - Total latency is N+2 edges.
- Signed mult: product negated (2N-bit two's complement) when sign(A)!=sign(B).
- Signed div:
  - Quotient negated when signs differ.
  - Remainder takes the sign of the dividend (MIPS truncation semantics).
- Divide by zero (B==0), divu and div:
  - lo=all ones, hi=A as presented at start; div_by_zero=1 with done.
  - Still takes the full N+2 latency.
- Signed overflow (div of 0x80000000 by 0xFFFFFFFF): lo=0x80000000, hi=0; no flag.
- Handshakes:
  - start while busy=1 is ignored; the in-flight op is unaffected.
  - start in the done cycle is accepted (state is IDLE).
- mthi/mtlo:
  - hi_we/lo_we write wd at the edge when busy=0 and start=0.
  - Ignored when busy=1, or when start=1 in the same cycle (start wins).
  - Both strobes together write both registers.
- hi/lo hold their values between operations; done is never asserted for mthi/mtlo.
- div_by_zero clears to 0 on the next start.

Test Plan:
- multu A=0xFFFFFFFF, B=0xFFFFFFFF, start at edge 0 -> busy cycles 1..33; done only at cycle 34; hi=0xFFFFFFFE, lo=0x00000001.
- mult A=0xFFFFFFFD (-3), B=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; then divu A=100, B=7 -> lo=14, hi=2, div_by_zero=0.
- div A=0xFFFFFFF9 (-7), B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; div A=7, B=0xFFFFFFFE -> lo=0xFFFFFFFD, hi=1.
- divu A=5, B=0 -> lo=0xFFFFFFFF, hi=5, div_by_zero=1 with done; div A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
- start mult 3*4, pulse start again with 9*9 at cycle 5, and hi_we=1 with wd=0x1234 at cycle 6 -> both ignored; lo=12, hi=0. Back-to-back start in the done cycle -> accepted. Afterwards hi_we with wd=0x1234 while idle -> hi=0x1234, no done.
- reset asserted asynchronously at cycle 10 of a divu -> busy, done, hi, lo go to 0 without waiting for clk. After release, no done pulse until a new start; a fresh multu 2*3 gives lo=6.
